fetch_byte_sequencer: RTL and testbench

Multi-cycle fetch stage for the sequential Y86-64 processor. Drives a byte address into the byte-wide, combinational-read instruction memory and collects one byte per cycle. Assembles icode/ifun, rA/rB and the 8-byte little-endian valC, and computes valP. Presents the decoded instruction to decode through a valid/ready handshake. Also tracks halt and instruction-memory errors.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/fetch_byte_sequencer_if.sv | 33 +++
 rtl/y86_ilen.sv | 28 ++
 rtl/fetch_byte_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fetch_byte_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: opcode values, register sentinel, fetch FSM states
// and instruction-format helpers used by the fetch stages.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] S_OP    = 3'd0;
  localparam logic [2:0] S_REG   = 3'd1;
  localparam logic [2:0] S_CONST = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
  } instr_t;

  localparam instr_t INSTR_EMPTY = '{icode: 4'h0, ifun: 4'h0, ra: RNONE, rb: RNONE, valc: 64'h0};

  function automatic logic has_regs(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ: has_regs = 1'b1;
      default:                has_regs = 1'b0;
    endcase
  endfunction

  function automatic logic has_const(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_JXX, I_CALL:          has_const = 1'b1;
      default:                has_const = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_byte_sequencer_if.sv
// Bus between the byte-serial fetch stage, instruction memory, the PC
// redirect source and decode.
interface fetch_byte_sequencer_if #(
  parameter int ADDR_W = 64
);
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_byte;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;
  logic [ADDR_W-1:0] valP;
  logic              instr_valid;
  logic              imem_error;
  logic              halted;

  modport master (
    input  pc_load, pc_in, mem_byte, out_ready,
    output mem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
           instr_valid, imem_error, halted
  );

  modport slave (
    output pc_load, pc_in, mem_byte, out_ready,
    input  mem_addr, out_valid, icode, ifun, rA, rB, valC, valP,
           instr_valid, imem_error, halted
  );
endinterface

// File: rtl/y86_ilen.sv
// Combinational Y86-64 instruction-format decoder: length in bytes and which
// optional fields follow the opcode byte.
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       has_regs_o,
  output logic       has_const_o,
  output logic       valid_o
);

  always_comb begin
    len_o = 4'd1;
    case (icode_i)
      I_HALT, I_NOP, I_RET:                  len_o = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:      len_o = 4'd2;
      I_JXX, I_CALL:                         len_o = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:          len_o = 4'd10;
      default:                               len_o = 4'd1;
    endcase
  end

  assign has_regs_o  = has_regs(icode_i);
  assign has_const_o = has_const(icode_i);
  assign valid_o     = (icode_i <= I_POPQ);

endmodule

// File: rtl/fetch_byte_sequencer.sv
// Multi-cycle Y86-64 fetch: reads one instruction byte per cycle, assembles the
// instruction fields and hands them to decode over a valid/ready handshake.
module fetch_byte_sequencer
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                MEM_BYTES = 128,
  parameter logic [ADDR_W-1:0] START_PC  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_byte_sequencer_if.master  bus
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] valp_q, valp_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        k_q, k_d;
  instr_t            ins_q, ins_d;
  logic              ov_q, ov_d;
  logic              err_q, err_d;
  logic              halt_q, halt_d;
  logic              iv_q, iv_d;

  logic [ADDR_W-1:0] addr;
  logic              addr_bad;
  logic [3:0]        len_b;
  logic              regs_b, const_b, valid_b;

  assign addr     = pc_q + ADDR_W'(cnt_q);
  assign addr_bad = (addr >= MEM_LIMIT);

  y86_ilen u_ilen (
    .icode_i     (bus.mem_byte[7:4]),
    .len_o       (len_b),
    .has_regs_o  (regs_b),
    .has_const_o (const_b),
    .valid_o     (valid_b)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valp_d  = valp_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    ins_d   = ins_q;
    ov_d    = ov_q;
    err_d   = err_q;
    halt_d  = halt_q;
    iv_d    = iv_q;

    case (state_q)
      S_OP: begin
        ins_d = INSTR_EMPTY;
        if (addr_bad) begin
          iv_d    = 1'b0;
          err_d   = 1'b1;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          ins_d.icode = bus.mem_byte[7:4];
          ins_d.ifun  = bus.mem_byte[3:0];
          iv_d        = valid_b;
          valp_d      = pc_q + ADDR_W'(len_b);
          k_d         = 3'd0;
          if (regs_b) begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_REG;
          end else if (const_b) begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_CONST;
          end else begin
            ov_d    = 1'b1;
            state_d = S_OUT;
          end
        end
      end

      S_REG: begin
        if (addr_bad) begin
          err_d   = 1'b1;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          ins_d.ra = bus.mem_byte[7:4];
          ins_d.rb = bus.mem_byte[3:0];
          if (has_const(ins_q.icode)) begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_CONST;
          end else begin
            ov_d    = 1'b1;
            state_d = S_OUT;
          end
        end
      end

      S_CONST: begin
        if (addr_bad) begin
          err_d   = 1'b1;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          ins_d.valc[{k_q, 3'b000} +: 8] = bus.mem_byte;
          if (k_q == 3'd7) begin
            ov_d    = 1'b1;
            state_d = S_OUT;
          end else begin
            k_d   = k_q + 3'd1;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_OUT: begin
        if (ov_q && bus.out_ready) begin
          ov_d = 1'b0;
          // A halt or a faulting fetch parks with the address of its last byte.
          if (ins_q.icode == I_HALT || err_q) begin
            halt_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = valp_q;
            cnt_d   = 4'd0;
            state_d = S_OP;
          end
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_OP;
      end
    endcase

    if (bus.pc_load) begin
      pc_d    = bus.pc_in;
      cnt_d   = 4'd0;
      k_d     = 3'd0;
      state_d = S_OP;
      ov_d    = 1'b0;
      err_d   = 1'b0;
      halt_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OP;
      pc_q    <= START_PC;
      valp_q  <= START_PC;
      cnt_q   <= 4'd0;
      k_q     <= 3'd0;
      ins_q   <= INSTR_EMPTY;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valp_q  <= valp_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      ins_q   <= ins_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      iv_q    <= iv_d;
    end
  end

  assign bus.mem_addr    = addr;
  assign bus.out_valid   = ov_q;
  assign bus.icode       = ins_q.icode;
  assign bus.ifun        = ins_q.ifun;
  assign bus.rA          = ins_q.ra;
  assign bus.rB          = ins_q.rb;
  assign bus.valC        = ins_q.valc;
  assign bus.valP        = valp_q;
  assign bus.instr_valid = iv_q;
  assign bus.imem_error  = err_q;
  assign bus.halted      = halt_q;

endmodule

// File: tb/tb_fetch_byte_sequencer.sv
// Directed bench for fetch_byte_sequencer: a vector table of single
// instructions plus hand-written handshake, halt, error and reset sequences.
module tb_fetch_byte_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_byte_sequencer_if #(.ADDR_W(64)) bus ();

  fetch_byte_sequencer #(
    .ADDR_W    (64),
    .MEM_BYTES (128),
    .START_PC  (64'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:127];
  assign bus.mem_byte = (bus.mem_addr < 64'd128) ? mem[bus.mem_addr[6:0]] : 8'hEE;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [79:0] bytes;
    logic [3:0]  nb;
    logic [3:0]  lat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        iv;
    logic        err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [63:0] pc, input logic [79:0] b, input int nb);
    for (int i = 0; i < nb; i++) mem[pc[6:0] + 7'(i)] = b[8*i +: 8];
  endtask

  task automatic redirect(input logic [63:0] pc);
    bus.pc_load = 1'b1;
    bus.pc_in   = pc;
    @(negedge clk);
    bus.pc_load = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk_fields(input string tag, input vec_t v);
    chk({tag, ".icode"}, 64'(bus.icode), 64'(v.icode));
    chk({tag, ".ifun"},  64'(bus.ifun),  64'(v.ifun));
    chk({tag, ".rA"},    64'(bus.rA),    64'(v.ra));
    chk({tag, ".rB"},    64'(bus.rB),    64'(v.rb));
    chk({tag, ".valC"},  bus.valC,       v.valc);
    chk({tag, ".valP"},  bus.valP,       v.valp);
    chk({tag, ".instr_valid"}, 64'(bus.instr_valid), 64'(v.iv));
    chk({tag, ".imem_error"},  64'(bus.imem_error),  64'(v.err));
  endtask

  initial begin
    int   c;
    vec_t v;
    vec_t irm;

    bus.pc_load   = 1'b0;
    bus.pc_in     = 64'h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h10;

    //        pc      bytes (byte0 in LSB)                      nb     lat    ic    ifn   rA    rB    valC                     valP     iv    err
    irm = '{64'h00, 80'h0A_F2_30,                             4'd10, 4'd10, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0A,                  64'h0A, 1'b1, 1'b0};
    vq.push_back(irm);
    vq.push_back('{64'h20, 80'h10,                            4'd1,  4'd1,  4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                   64'h21, 1'b1, 1'b0});
    vq.push_back('{64'h30, 80'h23_60,                         4'd2,  4'd2,  4'h6, 4'h0, 4'h2, 4'h3, 64'h0,                   64'h32, 1'b1, 1'b0});
    vq.push_back('{64'h40, 80'h11_22_33_44_55_66_77_88_74,    4'd9,  4'd9,  4'h7, 4'h4, 4'hF, 4'hF, 64'h1122334455667788,    64'h49, 1'b1, 1'b0});
    vq.push_back('{64'h50, 80'h01_23_45_67_89_AB_CD_EF_15_40, 4'd10, 4'd10, 4'h4, 4'h0, 4'h1, 4'h5, 64'h0123456789ABCDEF,    64'h5A, 1'b1, 1'b0});
    vq.push_back('{64'h60, 80'hC0,                            4'd1,  4'd1,  4'hC, 4'h0, 4'hF, 4'hF, 64'h0,                   64'h61, 1'b0, 1'b0});
    vq.push_back('{64'h66, 80'h90,                            4'd1,  4'd1,  4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                   64'h67, 1'b1, 1'b0});
    vq.push_back('{64'h68, 80'h07_06_05_04_03_02_01_00_80,    4'd9,  4'd9,  4'h8, 4'h0, 4'hF, 4'hF, 64'h0706050403020100,    64'h71, 1'b1, 1'b0});
    vq.push_back('{64'h0C, 80'h8F_B0,                         4'd2,  4'd2,  4'hB, 4'h0, 4'h8, 4'hF, 64'h0,                   64'h0E, 1'b1, 1'b0});
    vq.push_back('{64'h10, 80'hAB_21,                         4'd2,  4'd2,  4'h2, 4'h1, 4'hA, 4'hB, 64'h0,                   64'h12, 1'b1, 1'b0});
    vq.push_back('{64'h14, 80'h08_43_50,                      4'd10, 4'd10, 4'h5, 4'h0, 4'h4, 4'h3, 64'h08,                  64'h1E, 1'b1, 1'b0});
    vq.push_back('{64'h7E, 80'hAB_70,                         4'd2,  4'd3,  4'h7, 4'h0, 4'hF, 4'hF, 64'hAB,                  64'h87, 1'b1, 1'b1});

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid",   64'(bus.out_valid),   64'h0);
    chk("rst.halted",      64'(bus.halted),      64'h0);
    chk("rst.imem_error",  64'(bus.imem_error),  64'h0);
    chk("rst.instr_valid", 64'(bus.instr_valid), 64'h0);
    chk("rst.icode",       64'(bus.icode),       64'h0);
    chk("rst.rA",          64'(bus.rA),          64'hF);
    chk("rst.rB",          64'(bus.rB),          64'hF);
    chk("rst.valC",        bus.valC,             64'h0);
    chk("rst.valP",        bus.valP,             64'h0);
    chk("rst.mem_addr",    bus.mem_addr,         64'h0);

    // nop, addq, halt from START_PC with decode always ready
    load_mem(64'h0, 80'h00_23_60_10, 4);
    bus.out_ready = 1'b1;
    rst = 1'b0;
    wait_valid(c);
    chk("seq.nop.lat",   64'(c),         64'd1);
    chk("seq.nop.icode", 64'(bus.icode), 64'h1);
    chk("seq.nop.valP",  bus.valP,       64'h1);
    @(negedge clk);
    wait_valid(c);
    chk("seq.add.lat",   64'(c),         64'd2);
    chk("seq.add.icode", 64'(bus.icode), 64'h6);
    chk("seq.add.rA",    64'(bus.rA),    64'h2);
    chk("seq.add.rB",    64'(bus.rB),    64'h3);
    chk("seq.add.valP",  bus.valP,       64'h3);
    @(negedge clk);
    wait_valid(c);
    chk("seq.halt.lat",   64'(c),         64'd1);
    chk("seq.halt.icode", 64'(bus.icode), 64'h0);
    chk("seq.halt.valP",  bus.valP,       64'h4);
    @(negedge clk);
    chk("seq.halted",    64'(bus.halted),    64'h1);
    chk("seq.ov_off",    64'(bus.out_valid), 64'h0);
    chk("seq.mem_addr",  bus.mem_addr,       64'h3);
    repeat (3) @(negedge clk);
    chk("seq.hold.mem_addr", bus.mem_addr,       64'h3);
    chk("seq.hold.halted",   64'(bus.halted),    64'h1);
    chk("seq.hold.ov",       64'(bus.out_valid), 64'h0);

    // pc_load out of halt, then hold out_ready low on irmovq
    load_mem(irm.pc, irm.bytes, 32'(irm.nb));
    bus.out_ready = 1'b0;
    redirect(64'h0);
    chk("resume.halted",   64'(bus.halted), 64'h0);
    chk("resume.mem_addr", bus.mem_addr,    64'h0);
    wait_valid(c);
    chk("stall.lat", 64'(c), 64'd10);
    chk_fields("stall", irm);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.hold.ov",       64'(bus.out_valid), 64'h1);
      chk("stall.hold.valC",     bus.valC,           64'h0A);
      chk("stall.hold.rB",       64'(bus.rB),        64'h2);
      chk("stall.hold.valP",     bus.valP,           64'h0A);
      chk("stall.hold.mem_addr", bus.mem_addr,       64'h9);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stall.done.ov",       64'(bus.out_valid), 64'h0);
    chk("stall.done.mem_addr", bus.mem_addr,       64'h0A);

    // Reset while the fifth irmovq byte is on the bus
    redirect(64'h0);
    repeat (4) @(negedge clk);
    chk("midrst.pre.mem_addr", bus.mem_addr,    64'h4);
    chk("midrst.pre.icode",    64'(bus.icode),  64'h3);
    chk("midrst.pre.rB",       64'(bus.rB),     64'h2);
    #2 rst = 1'b1;
    #1;
    chk("midrst.icode",    64'(bus.icode),     64'h0);
    chk("midrst.rB",       64'(bus.rB),        64'hF);
    chk("midrst.mem_addr", bus.mem_addr,       64'h0);
    chk("midrst.valP",     bus.valP,           64'h0);
    chk("midrst.valC",     bus.valC,           64'h0);
    chk("midrst.ov",       64'(bus.out_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid(c);
    chk("midrst.restart.lat", 64'(c), 64'd10);
    chk_fields("midrst.restart", irm);

    // Vector table: each entry fetched after a redirect, left undelivered
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      load_mem(v.pc, v.bytes, 32'(v.nb));
      redirect(v.pc);
      wait_valid(c);
      chk($sformatf("vec%0d.lat", i), 64'(c), 64'(v.lat));
      chk_fields($sformatf("vec%0d", i), v);
    end

    // Invalid opcode delivered; sequencer continues at the next byte
    load_mem(64'h0, 80'h10_C0, 2);
    bus.out_ready = 1'b1;
    redirect(64'h0);
    wait_valid(c);
    chk("inv.lat",         64'(c),               64'd1);
    chk("inv.instr_valid", 64'(bus.instr_valid), 64'h0);
    chk("inv.icode",       64'(bus.icode),       64'hC);
    chk("inv.valP",        bus.valP,             64'h1);
    @(negedge clk);
    chk("inv.next.mem_addr", bus.mem_addr,       64'h1);
    chk("inv.next.ov",       64'(bus.out_valid), 64'h0);
    wait_valid(c);
    chk("inv.nop.lat",  64'(c),   64'd1);
    chk("inv.nop.valP", bus.valP, 64'h2);

    // Redirect coinciding with a handshake: redirect target wins
    bus.pc_load = 1'b1;
    bus.pc_in   = 64'h20;
    @(negedge clk);
    bus.pc_load = 1'b0;
    chk("both.mem_addr", bus.mem_addr,       64'h20);
    chk("both.ov",       64'(bus.out_valid), 64'h0);
    wait_valid(c);
    chk("both.lat",  64'(c),   64'd1);
    chk("both.valP", bus.valP, 64'h21);

    // Out-of-range constant byte, delivered then halted
    load_mem(64'h7E, 80'hAB_70, 2);
    redirect(64'h7E);
    wait_valid(c);
    chk("oor.lat",   64'(c),              64'd3);
    chk("oor.err",   64'(bus.imem_error), 64'h1);
    chk("oor.icode", 64'(bus.icode),      64'h7);
    chk("oor.valC",  bus.valC,            64'hAB);
    @(negedge clk);
    chk("oor.halted",   64'(bus.halted),    64'h1);
    chk("oor.ov",       64'(bus.out_valid), 64'h0);
    chk("oor.mem_addr", bus.mem_addr,       64'h80);
    redirect(64'h20);
    chk("oor.clr.halted", 64'(bus.halted),     64'h0);
    chk("oor.clr.err",    64'(bus.imem_error), 64'h0);
    chk("oor.clr.addr",   bus.mem_addr,        64'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
